// File: rtl/btn_pkg.sv
// Shared types for the push-button front end: event kinds, hold states
// and small helpers used by the per-button logic.
package btn_pkg;

    typedef enum logic [1:0] {
        PRESS   = 2'd0,
        RELEASE = 2'd1,
        LONG    = 2'd2,
        REPEAT  = 2'd3
    } evt_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        REPT = 2'd2
    } hold_state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Edge events replace a stale pending event; periodic ones never do.
    function automatic logic evt_overwrites(input evt_kind_t k);
        return (k == PRESS) || (k == RELEASE);
    endfunction

endpackage

// File: rtl/btn_filter.sv
// One button: 2-FF synchroniser followed by a stability counter.
// Level changes only after the synchronised input holds for DEB_CNT+1 cycles.
module btn_filter #(
    parameter int unsigned DEB_CNT = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int unsigned CW = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;
    localparam logic [CW-1:0] DEB_C = CW'(DEB_CNT);

    logic [1:0]    sync_q;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, fall_q;

    always_comb begin
        last_d  = last_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] != last_q) begin
            last_d = sync_q[1];
            cnt_d  = '0;
        end else if (last_q != level_q) begin
            if (cnt_q < DEB_C) cnt_d = cnt_q + 1'b1;
            else               level_d = last_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin_i};
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            // Strobes line up with the cycle the new level is first visible.
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// N-button front end: debounce, per-button hold FSM with a one-deep pending
// slot, and a round-robin arbiter feeding a single valid/ready event stream.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DEB_CNT  = 100,
    parameter int unsigned LONG_CNT = 50_000_000,
    parameter int unsigned REP_CNT  = 10_000_000,
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  btn_in,
    output logic [N-1:0]  btn_level,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [IW-1:0] evt_id,
    output logic [1:0]    evt_kind,
    output logic          evt_drop
);
    localparam int unsigned HW        = $clog2(max2(LONG_CNT, REP_CNT) + 1);
    localparam logic [HW-1:0] LONG_M1 = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] REP_M1  = HW'((REP_CNT > 0) ? REP_CNT - 1 : 0);

    logic [N-1:0]            rise, fall;
    logic [N-1:0]            slot_vld;
    evt_kind_t [N-1:0]       slot_kind;
    logic [N-1:0]            drop_vec;
    logic [N-1:0]            grant;

    logic                    load_ok;
    logic                    gnt_any;
    logic [IW-1:0]           gnt_idx;

    logic                    vld_q;
    logic [IW-1:0]           id_q;
    evt_kind_t               kind_q;
    logic [IW-1:0]           ptr_q;

    for (genvar i = 0; i < N; i++) begin : g_btn
        hold_state_t   state_q;
        logic [HW-1:0] hold_q;
        logic          ev_vld;
        evt_kind_t     ev_kind;
        logic          slot_vld_q;
        evt_kind_t     slot_kind_q;
        logic          drop_q;

        btn_filter #(.DEB_CNT(DEB_CNT)) u_filt (
            .clk     (clk),
            .reset   (reset),
            .pin_i   (btn_in[i]),
            .level_o (btn_level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );

        // Release outranks LONG/REPEAT when both land in the same cycle.
        always_comb begin
            ev_vld  = 1'b0;
            ev_kind = PRESS;
            unique case (state_q)
                IDLE: ev_vld = rise[i];
                HELD: begin
                    if (fall[i]) begin
                        ev_vld  = 1'b1;
                        ev_kind = RELEASE;
                    end else if (hold_q == LONG_M1) begin
                        ev_vld  = 1'b1;
                        ev_kind = LONG;
                    end
                end
                REPT: begin
                    if (fall[i]) begin
                        ev_vld  = 1'b1;
                        ev_kind = RELEASE;
                    end else if (REP_CNT != 0 && hold_q == REP_M1) begin
                        ev_vld  = 1'b1;
                        ev_kind = REPEAT;
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q     <= IDLE;
                hold_q      <= '0;
                slot_vld_q  <= 1'b0;
                slot_kind_q <= PRESS;
                drop_q      <= 1'b0;
            end else begin
                drop_q <= 1'b0;
                unique case (state_q)
                    IDLE: if (rise[i]) begin
                        state_q <= HELD;
                        hold_q  <= '0;
                    end
                    HELD: begin
                        if (fall[i]) begin
                            state_q <= IDLE;
                        end else if (hold_q == LONG_M1) begin
                            state_q <= REPT;
                            hold_q  <= '0;
                        end else begin
                            hold_q  <= hold_q + 1'b1;
                        end
                    end
                    REPT: begin
                        if (fall[i])                 state_q <= IDLE;
                        else if (REP_CNT != 0) begin
                            if (hold_q == REP_M1)    hold_q  <= '0;
                            else                     hold_q  <= hold_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                if (ev_vld) begin
                    if (!slot_vld_q || grant[i]) begin
                        slot_vld_q  <= 1'b1;
                        slot_kind_q <= ev_kind;
                    end else begin
                        drop_q <= 1'b1;
                        if (evt_overwrites(ev_kind)) slot_kind_q <= ev_kind;
                    end
                end else if (grant[i]) begin
                    slot_vld_q <= 1'b0;
                end
            end
        end

        assign slot_vld[i]  = slot_vld_q;
        assign slot_kind[i] = slot_kind_q;
        assign drop_vec[i]  = drop_q;
    end

    assign load_ok = !vld_q || evt_ready;

    // Walk from the far end back to ptr so the nearest valid slot wins.
    always_comb begin
        logic [IW-1:0] idx;
        int s;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        grant   = '0;
        idx     = '0;
        s       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(ptr_q) + k;
            if (s >= int'(N)) s = s - int'(N);
            idx = IW'(s);
            if (slot_vld[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (load_ok && gnt_any) grant[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            id_q   <= '0;
            kind_q <= PRESS;
            ptr_q  <= '0;
        end else if (load_ok) begin
            vld_q <= gnt_any;
            if (gnt_any) begin
                id_q   <= gnt_idx;
                kind_q <= slot_kind[gnt_idx];
                ptr_q  <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign evt_valid = vld_q;
    assign evt_id    = id_q;
    assign evt_kind  = kind_q;
    assign evt_drop  = |drop_vec;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with small counts (DEB 4, LONG 20, REP 8).
module tb_btn_event_ctrl;
    import btn_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level;
    logic         evt_valid;
    logic         evt_ready = 1'b1;
    logic [1:0]   evt_id;
    logic [1:0]   evt_kind;
    logic         evt_drop;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { int cyc; int id; int kind; } rec_t;
    rec_t log_q[$];

    always #5 clk = ~clk;

    btn_event_ctrl #(.N(N), .DEB_CNT(4), .LONG_CNT(20), .REP_CNT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_kind  (evt_kind),
        .evt_drop  (evt_drop)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && evt_valid && evt_ready)
            log_q.push_back(rec_t'{cyc, int'(evt_id), int'(evt_kind)});
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_vld(input int lim, output int n);
        n = 0;
        while (n < lim) begin
            @(posedge clk); #1;
            n++;
            if (evt_valid) return;
        end
        n = -1;
    endtask

    task automatic wait_lvl(input int b, input logic v, input int lim, output int n);
        n = 0;
        while (n < lim) begin
            @(posedge clk); #1;
            n++;
            if (btn_level[b] == v) return;
        end
        n = -1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    int n, m, hi, unstable, drops;
    int exp_kind[8] = '{0, 2, 3, 3, 3, 3, 3, 1};
    int exp_off[8]  = '{0, 20, 28, 36, 44, 52, 60, 68};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_id",    int'(evt_id),    0);
        chk("rst_kind",  int'(evt_kind),  0);
        chk("rst_drop",  int'(evt_drop),  0);
        chk("rst_level", int'(btn_level), 0);
        @(negedge clk); reset = 1'b0;

        // clean press and release of button 2
        @(negedge clk); btn_in[2] = 1'b1;
        wait_lvl(2, 1'b1, 30, n);
        chk("press_lvl_lat", n, 8);
        wait_vld(30, m);
        chk("press_vld_lat", n + m, 10);
        chk("press_id",   int'(evt_id),   2);
        chk("press_kind", int'(evt_kind), int'(PRESS));
        @(negedge clk); btn_in[2] = 1'b0;
        wait_lvl(2, 1'b0, 30, n);
        wait_vld(30, m);
        chk("rel_vld_lat", n + m, 10);
        chk("rel_kind", int'(evt_kind), int'(RELEASE));
        repeat (5) @(posedge clk);

        // bounce on button 0: runs of 3 cycles never qualify
        log_q.delete();
        hi = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c % 3 == 0) btn_in[0] = ~btn_in[0];
            if (btn_level[0]) hi++;
        end
        btn_in[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (btn_level[0]) hi++;
        end
        chk("bounce_lvl",  hi, 0);
        chk("bounce_evts", log_q.size(), 0);

        // long hold on button 1; last REPEAT coincides with the fall
        log_q.delete();
        @(negedge clk); btn_in[1] = 1'b1;
        wait_lvl(1, 1'b1, 30, n);
        repeat (60) @(posedge clk);
        #1 btn_in[1] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("hold_cnt", log_q.size(), 8);
        if (log_q.size() > 0) chk("hold_id", log_q[0].id, 1);
        for (int k = 0; k < log_q.size() && k < 8; k++) begin
            chk($sformatf("hold_kind%0d", k), log_q[k].kind, exp_kind[k]);
            chk($sformatf("hold_off%0d", k), log_q[k].cyc - log_q[0].cyc, exp_off[k]);
        end

        // simultaneous press of 0, 1, 3 from a fresh pointer
        pulse_reset();
        log_q.delete();
        @(negedge clk); btn_in = 4'b1011;
        repeat (16) @(posedge clk);
        #1;
        chk("arb_cnt", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("arb_id0", log_q[0].id, 0);
            chk("arb_id1", log_q[1].id, 1);
            chk("arb_id2", log_q[2].id, 3);
            chk("arb_kind2", log_q[2].kind, int'(PRESS));
            chk("arb_gap1", log_q[1].cyc - log_q[0].cyc, 1);
            chk("arb_gap2", log_q[2].cyc - log_q[1].cyc, 1);
        end
        chk("arb_ptr", int'(dut.ptr_q), 0);
        @(negedge clk); btn_in = '0;
        repeat (16) @(posedge clk);

        // backpressure: PRESS held, LONG queued, first REPEAT dropped
        pulse_reset();
        log_q.delete();
        evt_ready = 1'b0;
        @(negedge clk); btn_in[0] = 1'b1;
        wait_vld(30, n);
        chk("bp_lat",  n, 10);
        chk("bp_kind", int'(evt_kind), int'(PRESS));
        unstable = 0;
        drops = 0;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1;
            if (!evt_valid || evt_id != 2'd0 || evt_kind != 2'(PRESS)) unstable++;
            if (evt_drop) drops++;
        end
        chk("bp_stable", unstable, 0);
        chk("bp_drops",  drops, 1);
        evt_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_vld",  int'(evt_valid), 1);
        chk("bp_next_kind", int'(evt_kind),  int'(LONG));
        @(posedge clk); #1;
        chk("bp_log_cnt", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("bp_log0", log_q[0].kind, int'(PRESS));
            chk("bp_log1", log_q[1].kind, int'(LONG));
        end
        @(negedge clk); btn_in[0] = 1'b0;
        repeat (20) @(posedge clk);

        // reset while button 3 holds with PRESS presented
        pulse_reset();
        evt_ready = 1'b0;
        @(negedge clk); btn_in[3] = 1'b1;
        wait_vld(30, n);
        chk("rm_pre_id", int'(evt_id), 3);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("rm_valid", int'(evt_valid), 0);
        chk("rm_id",    int'(evt_id),    0);
        chk("rm_level", int'(btn_level), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_vld(30, n);
        chk("rm_lat",  n, 10);
        chk("rm_id2",  int'(evt_id),   3);
        chk("rm_kind", int'(evt_kind), int'(PRESS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

endmodule
